// File: rtl/tomasulo_pkg.sv
// Shared widths, opcodes and entry layout for the Tomasulo issue/RS/CDB slice.
package tomasulo_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int FUNC_W = 4;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'h0;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'h1;

  typedef struct packed {
    logic              busy;
    logic [FUNC_W-1:0] func;
    logic [TAG_W-1:0]  dest;
    logic              pend_j;
    logic [TAG_W-1:0]  tag_j;
    logic [DATA_W-1:0] val_j;
    logic              pend_k;
    logic [TAG_W-1:0]  tag_k;
    logic [DATA_W-1:0] val_k;
  } rs_entry_t;

  function automatic logic cdb_hit(input logic cv, input logic [TAG_W-1:0] ct,
                                   input logic [TAG_W-1:0] t);
    return cv && (ct == t);
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix for the reservation station; grants the oldest ready slot one-hot.
module rs_age_select #(
  parameter int N = 3
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] busy,
  input  logic [N-1:0] ready,
  output logic [N-1:0] grant
);

  // older[j][i] = 1 means slot j was allocated before slot i
  logic [N-1:0] older [N];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) older[j] <= '0;
    end else if (flush) begin
      for (int j = 0; j < N; j++) older[j] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alloc[i]) begin
          for (int j = 0; j < N; j++) begin
            older[j][i] <= busy[j] && (j != i);
            older[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    logic [N-1:0] col;
    grant = '0;
    col   = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) col[j] = older[j][i];
      grant[i] = ready[i] && ((ready & col) == '0);
    end
  end

endmodule

// File: rtl/add_rs_unit.sv
// Adder reservation station: allocates issued ops, snoops the CDB for pending
// operands and offers the oldest ready entry to the adder.
module add_rs_unit
  import tomasulo_pkg::*;
#(
  parameter int NUM_ENTRIES = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [FUNC_W-1:0] issue_func,
  input  logic [TAG_W-1:0]  issue_dest,
  input  logic              issue_qj_pend,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic              issue_qk_pend,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [FUNC_W-1:0] disp_func,
  output logic [DATA_W-1:0] disp_a,
  output logic [DATA_W-1:0] disp_b,
  output logic [TAG_W-1:0]  disp_dest,
  output logic [1:0]        add_count
);

  localparam logic [1:0] FULL = 2'(NUM_ENTRIES);

  rs_entry_t ent     [NUM_ENTRIES];
  rs_entry_t ent_nxt [NUM_ENTRIES];
  rs_entry_t new_ent;

  logic [NUM_ENTRIES-1:0] busy, ready, grant, free_oh, alloc_go;
  logic [1:0]             count_nxt;
  logic                   do_alloc, fire;

  assign issue_ready = (add_count < FULL);
  assign do_alloc    = issue_valid && issue_ready && !flush;
  assign disp_valid  = |ready;
  assign fire        = disp_valid && disp_ready;
  assign alloc_go    = free_oh & {NUM_ENTRIES{do_alloc}};

  always_comb begin
    logic found;
    found   = 1'b0;
    free_oh = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      busy[i]  = ent[i].busy;
      ready[i] = ent[i].busy && !ent[i].pend_j && !ent[i].pend_k;
      if (!ent[i].busy && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  rs_age_select #(.N(NUM_ENTRIES)) u_age (
    .clk1  (clk1),
    .rst_n (rst_n),
    .flush (flush),
    .alloc (alloc_go),
    .busy  (busy),
    .ready (ready),
    .grant (grant)
  );

  // grant is one-hot, so an OR-mux yields the selected entry and zero when idle
  always_comb begin
    disp_func = '0;
    disp_a    = '0;
    disp_b    = '0;
    disp_dest = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (grant[i]) begin
        disp_func = disp_func | ent[i].func;
        disp_a    = disp_a    | ent[i].val_j;
        disp_b    = disp_b    | ent[i].val_k;
        disp_dest = disp_dest | ent[i].dest;
      end
    end
  end

  // A pending operand whose producer broadcasts in the issue cycle is captured directly
  always_comb begin
    new_ent.busy   = 1'b1;
    new_ent.func   = issue_func;
    new_ent.dest   = issue_dest;
    new_ent.tag_j  = issue_qj;
    new_ent.tag_k  = issue_qk;
    new_ent.pend_j = issue_qj_pend && !cdb_hit(cdb_valid, cdb_tag, issue_qj);
    new_ent.pend_k = issue_qk_pend && !cdb_hit(cdb_valid, cdb_tag, issue_qk);
    new_ent.val_j  = (issue_qj_pend && cdb_hit(cdb_valid, cdb_tag, issue_qj)) ? cdb_data : issue_vj;
    new_ent.val_k  = (issue_qk_pend && cdb_hit(cdb_valid, cdb_tag, issue_qk)) ? cdb_data : issue_vk;
  end

  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_nxt[i] = ent[i];
      if (ent[i].busy && ent[i].pend_j && cdb_hit(cdb_valid, cdb_tag, ent[i].tag_j)) begin
        ent_nxt[i].pend_j = 1'b0;
        ent_nxt[i].val_j  = cdb_data;
      end
      if (ent[i].busy && ent[i].pend_k && cdb_hit(cdb_valid, cdb_tag, ent[i].tag_k)) begin
        ent_nxt[i].pend_k = 1'b0;
        ent_nxt[i].val_k  = cdb_data;
      end
      if (fire && grant[i]) ent_nxt[i].busy = 1'b0;
      if (alloc_go[i])      ent_nxt[i]      = new_ent;
      if (flush)            ent_nxt[i].busy = 1'b0;
      count_nxt = count_nxt + 2'(ent_nxt[i].busy);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= '0;
      add_count <= '0;
    end else begin
      ent       <= ent_nxt;
      add_count <= count_nxt;
    end
  end

endmodule

// File: doc/add_rs_unit.md
Name: add_rs_unit

Overview:
- Adder-class reservation station that sits directly downstream of the issue stage.
- Accepts one issued instruction per cycle, carrying operand values or ROB tags for pending operands, and holds it until both operands are available.
- Captures pending operands by snooping the common data bus (CDB).
- Dispatches the oldest ready entry to the adder functional unit; publishes its occupancy as the add_count seen by the issue stage.

Parameters:
NUM_ENTRIES, 3, number of reservation station slots
DATA_W, 16, operand/result width
TAG_W, 3, ROB index width (8-entry ROB)
FUNC_W, 4, opcode width

Ports:
clk1  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries (branch mispredict)
issue_valid  in  1  issue stage presents an instruction
issue_ready  out  1  at least one free slot
issue_func  in  FUNC_W  opcode
issue_dest  in  TAG_W  ROB tag of destination
issue_qj_pend  in  1  operand j is pending (use issue_qj)
issue_qj  in  TAG_W  producer tag for j
issue_vj  in  DATA_W  value for j when not pending
issue_qk_pend, issue_qk, issue_vk  in  1/TAG_W/DATA_W  same for operand k
cdb_valid  in  1  result broadcast valid
cdb_tag  in  TAG_W  ROB tag of broadcast result
cdb_data  in  DATA_W  broadcast value
disp_valid  out  1  a ready entry is offered to the adder
disp_ready  in  1  adder accepts this cycle
disp_func  out  FUNC_W  opcode of offered entry
disp_a, disp_b  out  DATA_W  operand values
disp_dest  out  TAG_W  ROB tag of offered entry
add_count  out  2  number of busy entries (0..NUM_ENTRIES)

Behaviour:
- Reset (async, rst_n=0): all busy bits 0, age matrix 0, add_count=0, issue_ready=1, disp_valid=0; disp_* data outputs are 0.
- Entry state:
  - busy, func, dest
  - per operand: pend, tag, value
  - age-matrix row
- Allocation: on issue_valid && issue_ready at the clk1 edge, the lowest-index free slot is written.
- Issue/CDB bypass at allocation: if an issued operand is pending and cdb_valid && cdb_tag matches its tag in the same cycle, the slot stores cdb_data with pend=0.
- Wakeup: every busy pending operand whose tag equals cdb_tag while cdb_valid=1 captures cdb_data and clears pend at the edge. Multiple entries and both operands may wake on one broadcast.
- Ready: an entry is ready when busy && !pend_j && !pend_k, evaluated on registered state. An entry woken this cycle is dispatchable next cycle, not in the same cycle.
- Selection:
  - Oldest ready entry wins, by age matrix: older[j][i]=1 means j was allocated before i.
  - Allocating slot i sets older[j][i]=1 for every busy j and clears row i.
  - disp_* outputs are combinational from the selected entry.
  - disp_valid is 1 iff any entry is ready.
- Dispatch: disp_valid && disp_ready frees the selected slot at the edge. Without disp_ready, the offer holds; a newly ready older entry may take over the offer, since the adder has not accepted.
- issue_ready = (add_count < NUM_ENTRIES). A slot freed in the current cycle does not count, so a full station accepts again one cycle after a dispatch.
- Simultaneous issue + dispatch in one cycle is legal; add_count updates by +1-1=0.
- issue_valid while issue_ready=0: ignored, no state change.
- flush=1: all busy bits cleared at the edge; any issue and CDB captures in that cycle are discarded. flush has priority over everything except rst_n.
- Reset asserted mid-operation: all state is lost immediately; no partial dispatch.
- add_count is registered: the popcount of busy after the edge.

Decomposition:
- tomasulo_pkg: DATA_W, TAG_W, FUNC_W constants; the rs_entry_t struct (busy, func, dest, pend/tag/value ×2); add/sub opcode constants shared with the issue stage.
- One sub-module, rs_age_select: holds the NUM_ENTRIES×NUM_ENTRIES age matrix and produces the one-hot oldest-ready grant from a ready vector.

Test Plan:
1. Reset, then issue ADD dest=2, vj=5, vk=7, neither operand pending -> next cycle disp_valid=1, disp_a=5, disp_b=7, disp_dest=2; with disp_ready=1, add_count returns 0.
2. Issue dest=3 with qj=1 pending; cdb_valid, tag=1, data=0x00AA two cycles later -> disp_valid stays 0 until the cycle after the broadcast, then disp_a=0x00AA.
3. Issue at the same edge as cdb_valid, tag=4, data=9, with issue_qk=4 pending -> entry stored ready; disp_b=9 on the next cycle.
4. Fill 3 entries, all pending (add_count=3, issue_ready=0); issue_valid ignored. Wake entries 2 and 0 together -> the older (allocated first) dispatches first.
5. Full station with disp_ready=1 and issue_valid=1 in the same cycle -> the issue is ignored and the dispatch completes; the next cycle issue_ready=1 and the issue is accepted, add_count=3.
6. Two busy entries; assert flush together with issue_valid=1 and a matching cdb -> after the edge add_count=0, disp_valid=0, issue_ready=1.
